// File: rtl/serial_div_pkg.sv
// Shared constants and the bit-order mode enum for the serial divisibility checker.
// Bit-order selection is only wired up when SERIAL_DIV_LSB_FIRST_EN is defined.
package serial_div_pkg;

   localparam int MIN_DIVISOR = 2;
   localparam int MAX_DIVISOR = 1024;

   typedef enum logic {
      MODE_MSB_FIRST = 1'b0,
      MODE_LSB_FIRST = 1'b1
   } mode_e;

   function automatic bit divisor_ok(input int d);
      return (d >= MIN_DIVISOR) && (d <= MAX_DIVISOR);
   endfunction

endpackage

// File: rtl/serial_mod_n_step.sv
// Combinational next-remainder / next-power step for one accepted serial bit.
// Every sum stays below 2*DIVISOR, so one conditional subtract replaces a divider.
module serial_mod_n_step
   import serial_div_pkg::*;
#(
   parameter  int DIVISOR = 5,
   localparam int REM_W   = $clog2(DIVISOR)
) (
   input  logic [REM_W-1:0] i_r,
   input  logic             i_bit,
   input  logic [REM_W-1:0] i_p,
   input  mode_e            i_mode,
   output logic [REM_W-1:0] o_r_next,
   output logic [REM_W-1:0] o_p_next
);

   localparam int             T_W   = REM_W + 1;
   localparam logic [T_W-1:0] DIV_T = T_W'(DIVISOR);

   logic [T_W-1:0] w_r_ext;
   logic [T_W-1:0] w_p_ext;
   logic [T_W-1:0] w_addend;
   logic [T_W-1:0] w_t;
   logic [T_W-1:0] w_pp;
   logic           w_r_bad;
   logic           w_p_bad;
   logic           w_t_ge;
   logic           w_pp_ge;

   assign w_r_ext = {1'b0, i_r};
   assign w_p_ext = {1'b0, i_p};
   assign w_r_bad = (w_r_ext >= DIV_T);
   assign w_p_bad = (w_p_ext >= DIV_T);

   always_comb begin
      w_addend = '0;
      w_t      = '0;
      unique case (i_mode)
         MODE_MSB_FIRST: begin
            w_t = {i_r, i_bit};
         end
         MODE_LSB_FIRST: begin
            w_addend = i_bit ? w_p_ext : '0;
            w_t      = w_r_ext + w_addend;
         end
         default: begin
            w_t = '0;
         end
      endcase
   end

   assign w_t_ge = (w_t >= DIV_T);

   // Out-of-range state collapses to 0 instead of propagating garbage.
   always_comb begin
      o_r_next = '0;
      unique case (1'b1)
         w_r_bad:                                 o_r_next = '0;
         (i_mode == MODE_LSB_FIRST) && w_p_bad:   o_r_next = '0;
         w_t_ge:                                  o_r_next = REM_W'(w_t - DIV_T);
         default:                                 o_r_next = w_t[REM_W-1:0];
      endcase
   end

   assign w_pp    = {i_p, 1'b0};
   assign w_pp_ge = (w_pp >= DIV_T);

   always_comb begin
      o_p_next = '0;
      unique case (1'b1)
         w_p_bad: o_p_next = REM_W'(1);
         w_pp_ge: o_p_next = REM_W'(w_pp - DIV_T);
         default: o_p_next = w_pp[REM_W-1:0];
      endcase
   end

endmodule

// File: rtl/serial_divisibility_mod_n.sv
// Serial mod-DIVISOR remainder tracker; reports divisibility of the bits seen so far.
// Define SERIAL_DIV_LSB_FIRST_EN to add the lsb_first port and the power register.
module serial_divisibility_mod_n
   import serial_div_pkg::*;
#(
   parameter  int DIVISOR = 5,
   localparam int REM_W   = $clog2(DIVISOR)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             start,
   input  logic             new_bit,
`ifdef SERIAL_DIV_LSB_FIRST_EN
   input  logic             lsb_first,
`endif
   output logic             div_by_n,
   output logic [REM_W-1:0] remainder,
   output logic             num_valid
);

   if (!divisor_ok(DIVISOR)) begin : g_bad_divisor
      $error("serial_divisibility_mod_n: DIVISOR out of range");
   end

   logic [REM_W-1:0] r_rem;
   logic             r_num_valid;
   logic [REM_W-1:0] w_r_in;
   logic [REM_W-1:0] w_p_in;
   logic [REM_W-1:0] w_r_next;
   logic [REM_W-1:0] w_p_next;
   mode_e            w_mode;

   // A start bit is just a step from the empty number (r=0, p=1).
   assign w_r_in = start ? '0 : r_rem;

`ifdef SERIAL_DIV_LSB_FIRST_EN
   logic [REM_W-1:0] r_pow;

   assign w_mode = lsb_first ? MODE_LSB_FIRST : MODE_MSB_FIRST;
   assign w_p_in = start ? REM_W'(1) : r_pow;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pow <= REM_W'(1);
      end else if (in_valid) begin
         r_pow <= w_p_next;
      end
   end
`else
   logic [REM_W-1:0] w_unused_p;

   assign w_mode     = MODE_MSB_FIRST;
   assign w_p_in     = REM_W'(1);
   assign w_unused_p = w_p_next;
`endif

   serial_mod_n_step #(
      .DIVISOR (DIVISOR)
   ) u_step (
      .i_r      (w_r_in),
      .i_bit    (new_bit),
      .i_p      (w_p_in),
      .i_mode   (w_mode),
      .o_r_next (w_r_next),
      .o_p_next (w_p_next)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rem       <= '0;
         r_num_valid <= 1'b0;
      end else if (in_valid) begin
         r_rem       <= w_r_next;
         r_num_valid <= 1'b1;
      end
   end

   assign remainder = r_rem;
   assign div_by_n  = (r_rem == '0);
   assign num_valid = r_num_valid;

endmodule

// File: tb/tb_serial_divisibility_mod_n.sv
// Bench for serial_divisibility_mod_n: directed tables, corner sequences, random streams.
// Four instances (N=5,3,7,1024) share one stimulus bus.
module tb_serial_divisibility_mod_n;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0;
   logic start = 1'b0;
   logic new_bit = 1'b0;
   logic lsb_first = 1'b0;

   logic [2:0] rem5;
   logic [1:0] rem3;
   logic [2:0] rem7;
   logic [9:0] rem1k;
   logic div5, div3, div7, div1k;
   logic nv5, nv3, nv7, nv1k;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_divisibility_mod_n #(.DIVISOR(5)) u_d5 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .start(start),
      .new_bit(new_bit),
`ifdef SERIAL_DIV_LSB_FIRST_EN
      .lsb_first(lsb_first),
`endif
      .div_by_n(div5), .remainder(rem5), .num_valid(nv5));

   serial_divisibility_mod_n #(.DIVISOR(3)) u_d3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .start(start),
      .new_bit(new_bit),
`ifdef SERIAL_DIV_LSB_FIRST_EN
      .lsb_first(lsb_first),
`endif
      .div_by_n(div3), .remainder(rem3), .num_valid(nv3));

   serial_divisibility_mod_n #(.DIVISOR(7)) u_d7 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .start(start),
      .new_bit(new_bit),
`ifdef SERIAL_DIV_LSB_FIRST_EN
      .lsb_first(lsb_first),
`endif
      .div_by_n(div7), .remainder(rem7), .num_valid(nv7));

   serial_divisibility_mod_n #(.DIVISOR(1024)) u_d1k (
      .clk(clk), .rst(rst), .in_valid(in_valid), .start(start),
      .new_bit(new_bit),
`ifdef SERIAL_DIV_LSB_FIRST_EN
      .lsb_first(lsb_first),
`endif
      .div_by_n(div1k), .remainder(rem1k), .num_valid(nv1k));

   typedef struct {
      bit vld;
      bit st;
      bit b;
      int exp_rem;
      bit exp_div;
      bit exp_nv;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", nm, act, exp);
      end
   endtask

   // Called at posedge+1; applies one cycle of inputs, returns at next posedge+1.
   task automatic drive(input bit v, input bit s, input bit b);
      in_valid = v;
      start    = s;
      new_bit  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      start    = 1'b0;
      new_bit  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_rand(input int nbits, input bit lsb);
      int dv[4];
      int mr[4];
      int mp[4];
      bit mnv;
      int acc;
      int guard;
      bit v, s, b;
      dv = '{5, 3, 7, 1024};
      lsb_first = lsb;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         mr[k] = 0;
         mp[k] = 1;
      end
      mnv   = 1'b0;
      acc   = 0;
      guard = 0;
      while (acc < nbits && guard < 4 * nbits) begin
         guard++;
         v = ($urandom_range(0, 7) != 0);
         s = ($urandom_range(0, 149) == 0);
         b = 1'($urandom);
         drive(v, s, b);
         if (v) begin
            acc++;
            mnv = 1'b1;
            for (int k = 0; k < 4; k++) begin
               if (s) begin
                  mr[k] = 0;
                  mp[k] = 1;
               end
               if (lsb) begin
                  mr[k] = (mr[k] + (b ? mp[k] : 0)) % dv[k];
                  mp[k] = (mp[k] * 2) % dv[k];
               end else begin
                  mr[k] = (mr[k] * 2 + int'(b)) % dv[k];
               end
            end
         end
         chk("rand_rem5", int'(rem5), mr[0]);
         chk("rand_rem3", int'(rem3), mr[1]);
         chk("rand_rem7", int'(rem7), mr[2]);
         chk("rand_rem1024", int'(rem1k), mr[3]);
         chk("rand_div1024", int'(div1k), int'(mr[3] == 0));
         chk("rand_div7", int'(div7), int'(mr[2] == 0));
         chk("rand_nv", int'(nv1k), int'(mnv));
      end
      chk("rand_budget", int'(acc >= nbits), 1);
      lsb_first = 1'b0;
   endtask

   vec_t tbl[9];

   initial begin
      tbl[0] = '{1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b1};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b1};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b1};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b1};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b1};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b1};
      tbl[8] = '{1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b1};

      // Reset is asynchronous: visible before any clock edge.
      #1;
      chk("rst_rem5", int'(rem5), 0);
      chk("rst_div5", int'(div5), 1);
      chk("rst_nv5", int'(nv5), 0);
      chk("rst_rem1024", int'(rem1k), 0);
      chk("rst_div7", int'(div7), 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_nv5", int'(nv5), 0);
      chk("idle_div5", int'(div5), 1);

      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].vld, tbl[i].st, tbl[i].b);
         chk($sformatf("tbl%0d_rem5", i), int'(rem5), tbl[i].exp_rem);
         chk($sformatf("tbl%0d_div5", i), int'(div5), int'(tbl[i].exp_div));
         chk($sformatf("tbl%0d_nv5", i), int'(nv5), int'(tbl[i].exp_nv));
      end

      // N=3: 1,1 then three idle cycles (start/new_bit ignored).
      do_reset();
      drive(1'b1, 1'b1, 1'b1);
      chk("n3_b1_rem", int'(rem3), 1);
      chk("n3_b1_div", int'(div3), 0);
      drive(1'b1, 1'b0, 1'b1);
      chk("n3_b2_rem", int'(rem3), 0);
      chk("n3_b2_div", int'(div3), 1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b1);
         chk($sformatf("n3_idle%0d_rem", i), int'(rem3), 0);
         chk($sformatf("n3_idle%0d_div", i), int'(div3), 1);
         chk($sformatf("n3_idle%0d_nv", i), int'(nv3), 1);
      end

      // N=7: 1,1,1 then reset pulsed mid-cycle.
      do_reset();
      drive(1'b1, 1'b1, 1'b1);
      chk("n7_b1_rem", int'(rem7), 1);
      drive(1'b1, 1'b0, 1'b1);
      chk("n7_b2_rem", int'(rem7), 3);
      drive(1'b1, 1'b0, 1'b1);
      chk("n7_b3_rem", int'(rem7), 0);
      chk("n7_b3_div", int'(div7), 1);
      chk("n7_b3_rem5", int'(rem5), 2);
      #3;
      rst = 1'b0;
      #1;
      chk("async_rem7", int'(rem7), 0);
      chk("async_nv7", int'(nv7), 0);
      chk("async_rem5", int'(rem5), 0);
      chk("async_div5", int'(div5), 1);
      chk("async_nv5", int'(nv5), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      // First bit after reset acts as a start even with start=0.
      drive(1'b1, 1'b0, 1'b1);
      chk("postrst_rem5", int'(rem5), 1);
      chk("postrst_nv5", int'(nv5), 1);
      drive(1'b1, 1'b0, 1'b1);
      chk("postrst2_rem5", int'(rem5), 3);
      chk("postrst2_rem7", int'(rem7), 3);

`ifdef SERIAL_DIV_LSB_FIRST_EN
      do_reset();
      lsb_first = 1'b1;
      begin
         int lb[4];
         int le[4];
         lb = '{0, 1, 0, 1};
         le = '{0, 2, 2, 0};
         for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 0), 1'(lb[i]));
            chk($sformatf("lsb%0d_rem5", i), int'(rem5), le[i]);
         end
      end
      lsb_first = 1'b0;
      run_rand(1000, 1'b1);
`endif

      run_rand(2000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_divisibility_mod_n.md
SERIAL_DIVISIBILITY_MOD_N -- requirements
Module: serial_divisibility_mod_n

Interface
REQ-001 Parameter DIVISOR, default 5: modulus N the serial number is tested against; legal range 2..1024.
REQ-002 Derived localparam REM_W = $clog2(DIVISOR): width of the remainder register.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  new_bit is accepted on a rising clk edge where in_valid=1.
REQ-006 start  input  1  qualified by in_valid; the accepted bit is the first bit of a new number.
REQ-007 new_bit  input  1  next serial bit of the number.
REQ-008 div_by_n  output  1  high when the number accepted so far is divisible by DIVISOR.
REQ-009 remainder  output  REM_W  current number mod DIVISOR.
REQ-010 num_valid  output  1  high once at least one bit has been accepted since reset or the last start.

Function
REQ-011 The state SHALL be the remainder r in 0..DIVISOR-1, held in a REM_W-bit register; one state per remainder.
REQ-012 MSB-first step: r_next = (2r + new_bit) mod DIVISOR, computed as t = 2r + new_bit on REM_W+1 bits, then t - DIVISOR if t >= DIVISOR; no divider or % operator.
REQ-013 The remainder SHALL update on the same edge as the accepted bit; div_by_n and remainder reflect it in the following cycle, so latency is 1 clk.
REQ-014 With in_valid=0, r, num_valid and all other state SHALL hold; start and new_bit are ignored.
REQ-015 in_valid=1 with start=1: r_next = new_bit (old r discarded) and num_valid set to 1.
REQ-016 in_valid=1 with start=0: normal step per REQ-012; num_valid set to 1.
REQ-017 div_by_n = (r == 0), decoded combinationally from the state register. It is high even when num_valid=0, because the empty number is 0.
REQ-018 The remainder register SHALL never hold a value >= DIVISOR; an illegal value recovers to 0 on the next accepted bit.
REQ-019 There is no limit on number length; state does not overflow or wrap regardless of bit count.

Reset
REQ-020 rst=0 SHALL immediately, without waiting for clk, force r=0, num_valid=0 and the LSB-first power register (REQ-023) to 1.
REQ-021 While rst=0, remainder=0, div_by_n=1 and num_valid=0.
REQ-022 Reset asserted mid-number discards the partial number; the first bit accepted after release behaves as if start=1.

Configuration
REQ-023 Macro SERIAL_DIV_LSB_FIRST_EN defined:
- adds input port lsb_first (1 bit), sampled on each accepted bit.
- lsb_first=1 steps as r_next = (r + new_bit*p) mod DIVISOR, then p_next = 2p mod DIVISOR.
- p is a REM_W-bit power register, reloaded to 1 on start (the start bit uses p=1, then p_next=2 mod DIVISOR).
- lsb_first=0 steps per REQ-012.
- Changing lsb_first mid-number is undefined; the bench does not do it.
REQ-024 Macro undefined: no lsb_first port, no p register, MSB-first only.

Structure
REQ-025 Package serial_div_pkg SHALL hold MAX_DIVISOR=1024, MIN_DIVISOR=2 and the mode enum (MODE_MSB_FIRST, MODE_LSB_FIRST).
REQ-026 An elaboration-time check SHALL reject DIVISOR outside MIN_DIVISOR..MAX_DIVISOR.
REQ-027 Sub-module serial_mod_n_step SHALL be combinational, parameter DIVISOR: inputs r, bit, p, mode; outputs r_next, p_next. The top holds all registers.

Verification
REQ-028 DIVISOR=5, start on first bit, bits 1,0,1,0 (value 10) -> remainder 1,2,0,0; div_by_n high after 3rd and 4th bits.
REQ-029 DIVISOR=3, bits 1,1 then 3 idle cycles with in_valid=0 -> remainder 1,0, held at 0; div_by_n stays 1.
REQ-030 DIVISOR=5, bits 1,0 (r=2), then start=1 with new_bit=1 -> remainder 1, num_valid stays 1.
REQ-031 DIVISOR=7, bits 1,1,1 then rst pulsed low between edges -> remainder 1,3,0, then 0 asynchronously with num_valid=0.
REQ-032 SERIAL_DIV_LSB_FIRST_EN, DIVISOR=5, lsb_first=1, bits 0,1,0,1 (value 10) -> remainder 0,2,2,0; p 1,2,4,3.
REQ-033 DIVISOR=1024 random MSB-first streams of 2000 bits -> remainder matches the reference model every cycle.
